// File: rtl/ecc_apb_pkg.sv
// Shared definitions for the ECC accelerator APB register bank:
// register byte offsets, STATUS bit positions and the APB FSM encoding.
package ecc_apb_pkg;

  localparam logic [4:0] REG_CTRL           = 5'h00;
  localparam logic [4:0] REG_DATA_IN        = 5'h04;
  localparam logic [4:0] REG_CODEWORD_WIDTH = 5'h08;
  localparam logic [4:0] REG_NOISE          = 5'h0C;
  localparam logic [4:0] REG_DATA_OUT       = 5'h10;
  localparam logic [4:0] REG_NUM_ERR        = 5'h14;
  localparam logic [4:0] REG_STATUS         = 5'h18;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_TIMEOUT = 2;

  // Encoding shared with the ECC controller's own APB state machine.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

endpackage

// File: rtl/ecc_busy_watchdog.sv
// Busy/done/timeout flags for the ECC operation in flight, with a watchdog
// that aborts an operation whose completion strobe never arrives.
module ecc_busy_watchdog
  import ecc_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic operation_done,
  input  logic status_read_clr,
  output logic o_busy,
  output logic o_done,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic          r_busy;
  logic          r_done;
  logic          r_timeout;
  logic          r_startDly;
  logic [CW-1:0] r_count;
  logic          w_expire;

  assign w_expire  = r_busy && (r_count == LAST_COUNT) && !operation_done && !start;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_timeout = r_timeout;

  // A strobe in the cycle right after a start belongs to the previous
  // operation, so busy stays set for the one just launched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_startDly <= 1'b0;
      r_count    <= '0;
    end else begin
      r_startDly <= start;
      if (start) begin
        r_busy  <= 1'b1;
        r_count <= '0;
      end else if (operation_done) begin
        r_busy  <= r_startDly;
        r_count <= '0;
      end else if (w_expire) begin
        r_busy  <= 1'b0;
        r_count <= '0;
      end else if (r_busy) begin
        r_count <= r_count + 1'b1;
      end
      r_done    <= operation_done | (r_done & ~status_read_clr);
      r_timeout <= w_expire | (r_timeout & ~status_read_clr);
    end
  end

endmodule

// File: rtl/ecc_apb_regfile.sv
// APB3 slave register bank in front of the ECC controller: configuration
// registers, result capture, start pulse and busy-stall of config writes.
module ecc_apb_regfile
  import ecc_apb_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic [AMBA_WORD-1:0]       CTRL,
  output logic [AMBA_WORD-1:0]       DATA_IN,
  output logic [AMBA_WORD-1:0]       CODEWORD_WIDTH,
  output logic [AMBA_WORD-1:0]       NOISE,
  output logic                       CTRL_ready,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  input  logic                       operation_done
);

  apb_state_t            r_state;
  logic [AMBA_WORD-1:0]  r_ctrl;
  logic [AMBA_WORD-1:0]  r_dataIn;
  logic [AMBA_WORD-1:0]  r_cwWidth;
  logic [AMBA_WORD-1:0]  r_noise;
  logic [DATA_WIDTH-1:0] r_dataOut;
  logic [1:0]            r_numErr;
  logic                  r_ctrlReady;

  logic [4:0] w_offset;
  logic       w_cfgAddr;
  logic       w_stall;
  logic       w_xfer;
  logic       w_wrCommit;
  logic       w_ctrlCommit;
  logic       w_statusClr;
  logic       w_busy;
  logic       w_done;
  logic       w_timeout;
  logic       w_unused_addr;

  assign w_offset      = {PADDR[4:2], 2'b00};
  assign w_unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};

  // Config writes wait while an operation runs; reads and RO writes never do.
  assign w_cfgAddr    = (w_offset <= REG_NOISE);
  assign w_stall      = PWRITE & w_busy & w_cfgAddr;
  assign PREADY       = (r_state == ACCESS) & ~w_stall;
  assign w_xfer       = PSEL & PENABLE & PREADY;
  assign w_wrCommit   = w_xfer & PWRITE;
  assign w_ctrlCommit = w_wrCommit & (w_offset == REG_CTRL);
  assign w_statusClr  = w_xfer & ~PWRITE & (w_offset == REG_STATUS);

  assign CTRL           = r_ctrl;
  assign DATA_IN        = r_dataIn;
  assign CODEWORD_WIDTH = r_cwWidth;
  assign NOISE          = r_noise;
  assign CTRL_ready     = r_ctrlReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (PSEL && !PENABLE) r_state <= SETUP;
        SETUP:   r_state <= PSEL ? ACCESS : IDLE;
        ACCESS: begin
          if (!PSEL)       r_state <= IDLE;
          else if (PREADY) r_state <= (PSEL && !PENABLE) ? SETUP : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl      <= '0;
      r_dataIn    <= '0;
      r_cwWidth   <= '0;
      r_noise     <= '0;
      r_dataOut   <= '0;
      r_numErr    <= '0;
      r_ctrlReady <= 1'b0;
    end else begin
      r_ctrlReady <= w_ctrlCommit;
      if (w_wrCommit) begin
        case (w_offset)
          REG_CTRL:           r_ctrl    <= PWDATA;
          REG_DATA_IN:        r_dataIn  <= PWDATA;
          REG_CODEWORD_WIDTH: r_cwWidth <= PWDATA;
          REG_NOISE:          r_noise   <= PWDATA;
          default: ;
        endcase
      end
      if (operation_done) begin
        r_dataOut <= data_out;
        r_numErr  <= num_of_errors;
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (r_state == ACCESS && !PWRITE) begin
      case (w_offset)
        REG_CTRL:           PRDATA = r_ctrl;
        REG_DATA_IN:        PRDATA = r_dataIn;
        REG_CODEWORD_WIDTH: PRDATA = r_cwWidth;
        REG_NOISE:          PRDATA = r_noise;
        REG_DATA_OUT:       PRDATA = AMBA_WORD'(r_dataOut);
        REG_NUM_ERR:        PRDATA = AMBA_WORD'(r_numErr);
        REG_STATUS: begin
          PRDATA[STATUS_BUSY]    = w_busy;
          PRDATA[STATUS_DONE]    = w_done;
          PRDATA[STATUS_TIMEOUT] = w_timeout;
        end
        default:            PRDATA = '0;
      endcase
    end
  end

  ecc_busy_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk             (clk),
    .reset           (reset),
    .start           (w_ctrlCommit),
    .operation_done  (operation_done),
    .status_read_clr (w_statusClr),
    .o_busy          (w_busy),
    .o_done          (w_done),
    .o_timeout       (w_timeout)
  );

endmodule

// File: tb/tb_ecc_apb_regfile.sv
// Directed bench for ecc_apb_regfile: a vector table for plain register
// accesses plus hand-written sequences for stall, watchdog and reset cases.
module tb_ecc_apb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [31:0] CTRL;
  logic [31:0] DATA_IN;
  logic [31:0] CODEWORD_WIDTH;
  logic [31:0] NOISE;
  logic        CTRL_ready;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        operation_done;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] data;
    logic [31:0] expRd;
    string       name;
  } vec_t;

  vec_t vecs[22];

  always #5 clk = ~clk;

  ecc_apb_regfile #(
    .AMBA_WORD(32),
    .AMBA_ADDR_WIDTH(20),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PADDR(PADDR),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .CTRL(CTRL),
    .DATA_IN(DATA_IN),
    .CODEWORD_WIDTH(CODEWORD_WIDTH),
    .NOISE(NOISE),
    .CTRL_ready(CTRL_ready),
    .data_out(data_out),
    .num_of_errors(num_of_errors),
    .operation_done(operation_done)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One full APB transfer; returns the read data and the number of wait cycles.
  task automatic applyStimulus(input logic [4:0] addr, input logic wr, input logic [31:0] data,
                               output logic [31:0] rd, output int waits);
    PADDR   = {15'd0, addr};
    PWRITE  = wr;
    PWDATA  = data;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    nextCycle();
    PENABLE = 1'b1;
    nextCycle();
    waits = 0;
    while (!PREADY && waits < 20) begin
      nextCycle();
      waits++;
    end
    rd = PRDATA;
    nextCycle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [4:0] addr, input logic [31:0] expected);
    logic [31:0] rd;
    int          waits;
    applyStimulus(addr, 1'b0, 32'h0, rd, waits);
    checkOutput(name, rd, expected);
  endtask

  task automatic writeCheck(input string name, input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    int          waits;
    applyStimulus(addr, 1'b1, data, rd, waits);
    checkOutput(name, 32'(waits), 32'd0);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (dut.w_busy && n < 40) begin
      nextCycle();
      n++;
    end
    checkOutput(name, 32'(dut.w_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required to end by 100000");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [31:0] rd;
    int          waits;

    vecs[0]  = '{5'h00, 1'b0, 32'h0,        32'h0,        "rst_rd_ctrl"};
    vecs[1]  = '{5'h04, 1'b0, 32'h0,        32'h0,        "rst_rd_data_in"};
    vecs[2]  = '{5'h08, 1'b0, 32'h0,        32'h0,        "rst_rd_cw"};
    vecs[3]  = '{5'h0C, 1'b0, 32'h0,        32'h0,        "rst_rd_noise"};
    vecs[4]  = '{5'h10, 1'b0, 32'h0,        32'h0,        "rst_rd_data_out"};
    vecs[5]  = '{5'h14, 1'b0, 32'h0,        32'h0,        "rst_rd_num_err"};
    vecs[6]  = '{5'h18, 1'b0, 32'h0,        32'h0,        "rst_rd_status"};
    vecs[7]  = '{5'h1C, 1'b0, 32'h0,        32'h0,        "rst_rd_unmapped"};
    vecs[8]  = '{5'h04, 1'b1, 32'hA5A50F0F, 32'h0,        "wr_data_in"};
    vecs[9]  = '{5'h08, 1'b1, 32'd32,       32'h0,        "wr_cw"};
    vecs[10] = '{5'h0C, 1'b1, 32'h00000004, 32'h0,        "wr_noise"};
    vecs[11] = '{5'h10, 1'b1, 32'hFFFFFFFF, 32'h0,        "wr_ro_data_out"};
    vecs[12] = '{5'h14, 1'b1, 32'h00000003, 32'h0,        "wr_ro_num_err"};
    vecs[13] = '{5'h18, 1'b1, 32'h00000007, 32'h0,        "wr_ro_status"};
    vecs[14] = '{5'h1C, 1'b1, 32'hDEADBEEF, 32'h0,        "wr_unmapped"};
    vecs[15] = '{5'h04, 1'b0, 32'h0,        32'hA5A50F0F, "rd_data_in"};
    vecs[16] = '{5'h08, 1'b0, 32'h0,        32'd32,       "rd_cw"};
    vecs[17] = '{5'h0C, 1'b0, 32'h0,        32'h00000004, "rd_noise"};
    vecs[18] = '{5'h10, 1'b0, 32'h0,        32'h0,        "rd_data_out_ro"};
    vecs[19] = '{5'h14, 1'b0, 32'h0,        32'h0,        "rd_num_err_ro"};
    vecs[20] = '{5'h18, 1'b0, 32'h0,        32'h0,        "rd_status_ro"};
    vecs[21] = '{5'h1C, 1'b0, 32'h0,        32'h0,        "rd_unmapped"};

    reset          = 1'b1;
    PADDR          = '0;
    PSEL           = 1'b0;
    PENABLE        = 1'b0;
    PWRITE         = 1'b0;
    PWDATA         = '0;
    data_out       = '0;
    num_of_errors  = '0;
    operation_done = 1'b0;
    repeat (3) nextCycle();
    reset = 1'b0;
    nextCycle();

    checkOutput("rst_pready", 32'(PREADY), 32'd0);
    checkOutput("rst_ctrl_ready", 32'(CTRL_ready), 32'd0);
    checkOutput("rst_ctrl", CTRL, 32'h0);
    checkOutput("rst_state", 32'(dut.r_state), 32'd0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].data, rd, waits);
      checkOutput({vecs[i].name, "_waits"}, 32'(waits), 32'd0);
      if (!vecs[i].wr) checkOutput(vecs[i].name, rd, vecs[i].expRd);
    end

    $display("[TB] CTRL trigger and start pulse");
    applyStimulus(5'h00, 1'b1, 32'h2, rd, waits);
    checkOutput("ctrl_pulse_hi", 32'(CTRL_ready), 32'd1);
    checkOutput("ctrl_out", CTRL, 32'h2);
    checkOutput("data_in_out", DATA_IN, 32'hA5A50F0F);
    checkOutput("cw_out", CODEWORD_WIDTH, 32'd32);
    checkOutput("noise_out", NOISE, 32'h4);
    nextCycle();
    checkOutput("ctrl_pulse_lo", 32'(CTRL_ready), 32'd0);
    readCheck("status_busy", 5'h18, 32'h1);
    waitIdle("first_op_timeout");
    readCheck("status_timeout", 5'h18, 32'h4);
    readCheck("status_cleared", 5'h18, 32'h0);

    $display("[TB] stalled config write completed by operation_done");
    applyStimulus(5'h00, 1'b1, 32'h2, rd, waits);
    checkOutput("same_ctrl_pulse", 32'(CTRL_ready), 32'd1);
    PADDR = 20'h4; PWRITE = 1'b1; PWDATA = 32'h1234; PSEL = 1'b1; PENABLE = 1'b0;
    nextCycle();
    PENABLE = 1'b1;
    nextCycle();
    checkOutput("stall_c0", 32'(PREADY), 32'd0);
    nextCycle();
    checkOutput("stall_c1", 32'(PREADY), 32'd0);
    nextCycle();
    checkOutput("stall_c2", 32'(PREADY), 32'd0);
    operation_done = 1'b1; data_out = 32'hA5A50F0B; num_of_errors = 2'd1;
    nextCycle();
    operation_done = 1'b0;
    checkOutput("stall_release", 32'(PREADY), 32'd1);
    checkOutput("stall_no_early_write", DATA_IN, 32'hA5A50F0F);
    nextCycle();
    checkOutput("stall_write_done", DATA_IN, 32'h1234);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    readCheck("data_out_captured", 5'h10, 32'hA5A50F0B);
    readCheck("num_err_captured", 5'h14, 32'h1);
    readCheck("status_done", 5'h18, 32'h2);
    readCheck("status_done_clr", 5'h18, 32'h0);

    $display("[TB] read while busy");
    applyStimulus(5'h00, 1'b1, 32'h3, rd, waits);
    applyStimulus(5'h10, 1'b0, 32'h0, rd, waits);
    checkOutput("busy_read_waits", 32'(waits), 32'd0);
    checkOutput("busy_read_data", rd, 32'hA5A50F0B);
    waitIdle("busy_read_op_timeout");
    readCheck("status_timeout2", 5'h18, 32'h4);

    $display("[TB] watchdog expiry timing");
    applyStimulus(5'h00, 1'b1, 32'h1, rd, waits);
    repeat (7) nextCycle();
    checkOutput("wd_busy_last", 32'(dut.w_busy), 32'd1);
    nextCycle();
    checkOutput("wd_busy_cleared", 32'(dut.w_busy), 32'd0);
    readCheck("wd_status", 5'h18, 32'h4);
    applyStimulus(5'h00, 1'b1, 32'h6, rd, waits);
    checkOutput("post_wd_ctrl_waits", 32'(waits), 32'd0);
    checkOutput("post_wd_ctrl_pulse", 32'(CTRL_ready), 32'd1);

    $display("[TB] expiry and done on the same edge");
    repeat (7) nextCycle();
    operation_done = 1'b1; data_out = 32'h11; num_of_errors = 2'd2;
    nextCycle();
    operation_done = 1'b0;
    checkOutput("tie_busy", 32'(dut.w_busy), 32'd0);
    readCheck("tie_status", 5'h18, 32'h2);
    readCheck("tie_num_err", 5'h14, 32'h2);
    readCheck("tie_data_out", 5'h10, 32'h11);

    $display("[TB] done during the start pulse");
    applyStimulus(5'h00, 1'b1, 32'h7, rd, waits);
    operation_done = 1'b1; data_out = 32'h22; num_of_errors = 2'd3;
    nextCycle();
    operation_done = 1'b0;
    checkOutput("overlap_busy", 32'(dut.w_busy), 32'd1);
    readCheck("overlap_status", 5'h18, 32'h3);
    readCheck("overlap_data_out", 5'h10, 32'h22);
    waitIdle("overlap_op_timeout");
    readCheck("overlap_status_to", 5'h18, 32'h4);

    $display("[TB] reset during a CTRL access phase");
    PADDR = 20'h0; PWRITE = 1'b1; PWDATA = 32'h5; PSEL = 1'b1; PENABLE = 1'b0;
    nextCycle();
    PENABLE = 1'b1;
    nextCycle();
    checkOutput("rst_mid_pready", 32'(PREADY), 32'd1);
    reset = 1'b1;
    nextCycle();
    checkOutput("rst_mid_ctrl_ready", 32'(CTRL_ready), 32'd0);
    checkOutput("rst_mid_ctrl", CTRL, 32'h0);
    checkOutput("rst_mid_data_in", DATA_IN, 32'h0);
    checkOutput("rst_mid_state", 32'(dut.r_state), 32'd0);
    checkOutput("rst_mid_pready_lo", 32'(PREADY), 32'd0);
    reset = 1'b0;
    PADDR = 20'h4; PWDATA = 32'hCAFE; PENABLE = 1'b0;
    nextCycle();
    checkOutput("b2b_setup", 32'(dut.r_state), 32'd1);
    PENABLE = 1'b1;
    nextCycle();
    checkOutput("b2b_access", 32'(dut.r_state), 32'd2);
    checkOutput("b2b_pready", 32'(PREADY), 32'd1);
    nextCycle();
    checkOutput("b2b_first", DATA_IN, 32'hCAFE);
    PADDR = 20'hC; PWDATA = 32'hBEEF; PENABLE = 1'b0;
    nextCycle();
    PENABLE = 1'b1;
    nextCycle();
    checkOutput("b2b_second_pready", 32'(PREADY), 32'd1);
    nextCycle();
    checkOutput("b2b_second", NOISE, 32'hBEEF);
    checkOutput("b2b_no_pulse", 32'(CTRL_ready), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
